prefetch_issue_queue: RTL and testbench

Sits directly downstream of the best-offset prefetcher and buffers its prefetch candidates (prefetch address plus the triggering demand address) before they reach the lower-level cache. Each candidate is line-aligned and checked against a page-crossing rule, the queue contents and a small filter of recently issued lines. Accepted candidates are queued in a FIFO and issued with a valid/ready handshake. Issue is throttled by lower-level MSHR occupancy.

---
 rtl/prefetch_issue_queue.sv | 151 +++++++++++++++
 tb/tb_prefetch_issue_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_issue_queue.sv
// Prefetch issue queue: filters best-offset prefetch candidates (page, duplicate, full)
// and issues line-aligned requests through a valid/ready port throttled by MSHR occupancy.
module prefetch_issue_queue #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 8,
    parameter int FILTER_SIZE = 16,
    parameter int LOGLINE     = 6,
    parameter int LOGPAGE     = 12,
    parameter int MSHR_WIDTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pf_address_i,
    input  logic [WIDTH-1:0]         pf_trigger_i,
    input  logic                     pf_valid_i,
    input  logic [MSHR_WIDTH-1:0]    mshr_occupancy_i,
    input  logic [MSHR_WIDTH-1:0]    mshr_threshold_i,
    output logic [WIDTH-1:0]         req_address_o,
    output logic                     req_valid_o,
    input  logic                     req_ready_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic [CNT_WIDTH-1:0]     drop_page_o,
    output logic [CNT_WIDTH-1:0]     drop_dup_o,
    output logic [CNT_WIDTH-1:0]     drop_full_o,
    output logic                     dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int LW = WIDTH - LOGLINE;

    // Handshake: a request transfers on any rising edge where req_valid_o and req_ready_i
    // are both high; once raised, valid and address hold until that transfer.
    typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]          mem_q [DEPTH];
    logic [LW-1:0]          mem_d [DEPTH];
    logic [FILTER_SIZE-1:0] flt_valid_q, flt_valid_d;
    logic [LW-1:0]          flt_la_q [FILTER_SIZE];
    logic [LW-1:0]          flt_la_d [FILTER_SIZE];
    logic [FW-1:0]          flt_ptr_q, flt_ptr_d;
    logic [CNT_WIDTH-1:0]   drop_page_q, drop_page_d, drop_dup_q, drop_dup_d, drop_full_q, drop_full_d;

    logic [AW:0]   occ, occ_next;
    logic [LW-1:0] cand_la, head_la;
    logic [AW-1:0] rel;
    logic          page_ok, dup_hit, full, enq, deq, throttle_ok;

    assign occ         = wr_ptr_q - rd_ptr_q;
    assign full        = (occ == (AW+1)'(DEPTH));
    assign cand_la     = pf_address_i[WIDTH-1:LOGLINE];
    assign head_la     = mem_q[rd_ptr_q[AW-1:0]];
    assign page_ok     = (pf_address_i[WIDTH-1:LOGPAGE] == pf_trigger_i[WIDTH-1:LOGPAGE]);
    assign throttle_ok = (mshr_occupancy_i < mshr_threshold_i);
    assign deq         = (state_q == S_PRESENT) && req_ready_i;
    assign enq         = pf_valid_i && page_ok && !dup_hit && !full;
    assign occ_next    = occ + (AW+1)'(enq) - (AW+1)'(deq);

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        dup_hit = 1'b0;
        rel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = AW'(i) - rd_ptr_q[AW-1:0];
            if (({1'b0, rel} < occ) && (mem_q[i] == cand_la)) dup_hit = 1'b1;
        end
        for (int j = 0; j < FILTER_SIZE; j++) begin
            if (flt_valid_q[j] && (flt_la_q[j] == cand_la)) dup_hit = 1'b1;
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        flt_la_d    = flt_la_q;
        flt_valid_d = flt_valid_q;
        flt_ptr_d   = flt_ptr_q;
        drop_page_d = drop_page_q;
        drop_dup_d  = drop_dup_q;
        drop_full_d = drop_full_q;
        if (enq) begin
            mem_d[wr_ptr_q[AW-1:0]] = cand_la;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (deq) begin
            rd_ptr_d              = rd_ptr_q + (AW+1)'(1);
            flt_la_d[flt_ptr_q]    = head_la;
            flt_valid_d[flt_ptr_q] = 1'b1;
            flt_ptr_d = (flt_ptr_q == FW'(FILTER_SIZE-1)) ? '0 : flt_ptr_q + FW'(1);
        end
        if (pf_valid_i && !page_ok && (drop_page_q != '1))
            drop_page_d = drop_page_q + CNT_WIDTH'(1);
        if (pf_valid_i && page_ok && dup_hit && (drop_dup_q != '1))
            drop_dup_d = drop_dup_q + CNT_WIDTH'(1);
        if (pf_valid_i && page_ok && !dup_hit && full && (drop_full_q != '1))
            drop_full_d = drop_full_q + CNT_WIDTH'(1);
    end

    // "Still holds another entry" counts a same-cycle enqueue, giving 1-cycle issue latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if ((occ_next != '0) && throttle_ok) state_d = S_PRESENT;
            S_PRESENT: if (req_ready_i) state_d = ((occ_next != '0) && throttle_ok) ? S_PRESENT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_valid_o   = (state_q == S_PRESENT);
        req_address_o = '0;
        if (state_q == S_PRESENT) req_address_o = {head_la, {LOGLINE{1'b0}}};
    end

    assign occupancy_o = occ;
    assign drop_page_o = drop_page_q;
    assign drop_dup_o  = drop_dup_q;
    assign drop_full_o = drop_full_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            flt_valid_q <= '0;
            flt_ptr_q   <= '0;
            drop_page_q <= '0;
            drop_dup_q  <= '0;
            drop_full_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            flt_valid_q <= flt_valid_d;
            flt_ptr_q   <= flt_ptr_d;
            drop_page_q <= drop_page_d;
            drop_dup_q  <= drop_dup_d;
            drop_full_q <= drop_full_d;
        end
    end

    // Storage arrays are qualified by pointers and valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        flt_la_q <= flt_la_d;
    end
endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Bench for prefetch_issue_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_prefetch_issue_queue;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int FILTER_SIZE = 16;
  localparam int LOGLINE = 6;
  localparam int LOGPAGE = 12;
  localparam int CNT_MAX = 65535;
  localparam int LW = WIDTH - LOGLINE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] pf_address_i = '0;
  logic [WIDTH-1:0] pf_trigger_i = '0;
  logic             pf_valid_i = 1'b0;
  logic [3:0]       mshr_occupancy_i = '0;
  logic [3:0]       mshr_threshold_i = 4'd4;
  logic [WIDTH-1:0] req_address_o;
  logic             req_valid_o;
  logic             req_ready_i = 1'b0;
  logic [3:0]       occupancy_o;
  logic [15:0]      drop_page_o, drop_dup_o, drop_full_o;
  logic             dbg_state_o;

  prefetch_issue_queue dut (
    .clk(clk), .rst(rst),
    .pf_address_i(pf_address_i), .pf_trigger_i(pf_trigger_i), .pf_valid_i(pf_valid_i),
    .mshr_occupancy_i(mshr_occupancy_i), .mshr_threshold_i(mshr_threshold_i),
    .req_address_o(req_address_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .occupancy_o(occupancy_o), .drop_page_o(drop_page_o), .drop_dup_o(drop_dup_o),
    .drop_full_o(drop_full_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queued line addresses, last FILTER_SIZE issued lines, request flag
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] flt_q[$];
  bit m_valid = 1'b0;
  int m_page = 0;
  int m_dup = 0;
  int m_full = 0;

  task automatic model_step();
    logic [LW-1:0] la;
    logic [LW-1:0] head;
    bit dup;
    bit acc;
    bit do_enq;
    la = pf_address_i[WIDTH-1:LOGLINE];
    acc = m_valid && req_ready_i;
    dup = 1'b0;
    do_enq = 1'b0;
    foreach (exp_q[i]) if (exp_q[i] == la) dup = 1'b1;
    foreach (flt_q[i]) if (flt_q[i] == la) dup = 1'b1;
    if (pf_valid_i) begin
      if ((pf_address_i >> LOGPAGE) != (pf_trigger_i >> LOGPAGE)) begin
        if (m_page < CNT_MAX) m_page++;
      end else if (dup) begin
        if (m_dup < CNT_MAX) m_dup++;
      end else if (exp_q.size() == DEPTH) begin
        if (m_full < CNT_MAX) m_full++;
      end else begin
        do_enq = 1'b1;
      end
    end
    if (acc) begin
      head = exp_q.pop_front();
      flt_q.push_back(head);
      if (flt_q.size() > FILTER_SIZE) void'(flt_q.pop_front());
    end
    if (do_enq) exp_q.push_back(la);
    if (!m_valid || acc)
      m_valid = (exp_q.size() != 0) && (mshr_occupancy_i < mshr_threshold_i);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        flt_q.delete();
        m_valid = 1'b0;
        m_page = 0;
        m_dup = 0;
        m_full = 0;
      end else begin
        model_step();
      end
    end
  end

  // scoreboard compare on the falling edge
  initial begin
    logic [63:0] exp_addr;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_addr = '0;
      if (m_valid && exp_q.size() != 0) exp_addr = {exp_q[0], 6'b0};
      check("cyc_req_valid", req_valid_o, m_valid);
      check("cyc_req_address", req_address_o, exp_addr);
      check("cyc_occupancy", occupancy_o, exp_q.size());
      check("cyc_drop_page", drop_page_o, m_page);
      check("cyc_drop_dup", drop_dup_o, m_dup);
      check("cyc_drop_full", drop_full_o, m_full);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] addr, input logic [63:0] trig);
    pf_address_i = addr;
    pf_trigger_i = trig;
    pf_valid_i = 1'b1;
    tick();
    pf_valid_i = 1'b0;
  endtask

  initial begin
    #3 rst = 1'b0;
    tick();
    tick();
    check("reset_valid", req_valid_o, 0);
    check("reset_addr", req_address_o, 0);
    check("reset_occ", occupancy_o, 0);
    check("reset_cnt", {drop_page_o, drop_dup_o, drop_full_o}, 0);
    rst = 1'b1;
    tick();

    // single candidate, 1-cycle latency
    req_ready_i = 1'b1;
    send(64'h1048, 64'h1000);
    check("single_valid", req_valid_o, 1);
    check("single_addr", req_address_o, 64'h1040);
    tick();
    check("single_done_valid", req_valid_o, 0);
    check("single_done_occ", occupancy_o, 0);

    // page crossing
    send(64'h2000, 64'h1FC0);
    check("page_cnt", drop_page_o, 1);
    check("page_others", {drop_dup_o, drop_full_o}, 0);
    check("page_occ", occupancy_o, 0);

    // duplicates in the FIFO, then in the filter
    req_ready_i = 1'b0;
    send(64'h3000, 64'h3000);
    send(64'h3010, 64'h3000);
    check("dup_fifo_occ", occupancy_o, 1);
    check("dup_fifo_cnt", drop_dup_o, 1);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    send(64'h3020, 64'h3000);
    check("dup_filter_cnt", drop_dup_o, 2);
    req_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) send(64'h4000 + 64'(i) * 64'h40, 64'h4000);
    tick();
    tick();
    send(64'h3000, 64'h3000);
    check("evicted_valid", req_valid_o, 1);
    check("evicted_addr", req_address_o, 64'h3000);
    check("evicted_dup_cnt", drop_dup_o, 2);
    tick();

    // fill past full, then drain in order
    req_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) send(64'h5000 + 64'(i) * 64'h40, 64'h5000);
    check("full_occ", occupancy_o, 8);
    check("full_cnt", drop_full_o, 2);
    req_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", req_valid_o, 1);
      check("drain_addr", req_address_o, 64'h5000 + 64'(i) * 64'h40);
      tick();
    end
    check("drained_valid", req_valid_o, 0);
    check("drained_occ", occupancy_o, 0);

    // pointer wrap with back-to-back enqueue/issue
    for (int i = 0; i < 8; i++) send(64'h6000 + 64'(i) * 64'h40, 64'h6000);
    tick();
    tick();

    // throttle and hold
    req_ready_i = 1'b0;
    mshr_occupancy_i = 4'd4;
    send(64'h7000, 64'h7000);
    tick();
    check("throttle_valid", req_valid_o, 0);
    check("throttle_occ", occupancy_o, 1);
    mshr_occupancy_i = 4'd3;
    tick();
    check("unthrottle_valid", req_valid_o, 1);
    check("unthrottle_addr", req_address_o, 64'h7000);
    mshr_occupancy_i = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", req_valid_o, 1);
      check("hold_addr", req_address_o, 64'h7000);
    end
    req_ready_i = 1'b1;
    tick();
    check("hold_done_valid", req_valid_o, 0);
    mshr_occupancy_i = 4'd0;

    // asynchronous reset while presenting with 3 entries
    req_ready_i = 1'b0;
    send(64'h8000, 64'h8000);
    send(64'h8040, 64'h8000);
    send(64'h8080, 64'h8000);
    check("pre_reset_occ", occupancy_o, 3);
    #2 rst = 1'b0;
    #1;
    check("async_valid", req_valid_o, 0);
    check("async_addr", req_address_o, 0);
    check("async_occ", occupancy_o, 0);
    check("async_cnt", {drop_page_o, drop_dup_o, drop_full_o}, 0);
    tick();
    rst = 1'b1;
    tick();
    req_ready_i = 1'b1;
    send(64'h9000, 64'h9000);
    check("post_reset_valid", req_valid_o, 1);
    check("post_reset_addr", req_address_o, 64'h9000);
    tick();
    check("post_reset_done", req_valid_o, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
